// File: rtl/systolic_tile_seq_pkg.sv
// Shared types and default sizes for the systolic tile sequencer.
package systolic_pkg;

  localparam int DIM_DEF = 8;
  localparam int KW_DEF  = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    COMPUTE,
    DRAIN,
    DONE
  } state_t;

  // Step counter must reach k_len + 2*DIM - 3 at the largest k_len without wrapping.
  function automatic int cnt_width(input int dim, input int kw);
    int skew_w;
    skew_w = $clog2(2 * dim);
    return ((kw > skew_w) ? kw : skew_w) + 1;
  endfunction

endpackage

// File: rtl/systolic_tile_seq_if.sv
// Control, array-drive and drain signals of the systolic tile sequencer.
interface systolic_tile_seq_if
  import systolic_pkg::*;
#(
  parameter int DIM = DIM_DEF,
  parameter int KW  = KW_DEF
);
  localparam int RW = (DIM > 1) ? $clog2(DIM) : 1;

  logic           start;
  logic           abort;
  logic [KW-1:0]  k_len;
  logic           busy;
  logic           done;
  logic           err;
  logic           ld_en;
  logic [RW-1:0]  ld_row;
  logic           acc_clr;
  logic [DIM-1:0] feed_en;
  logic           drain_valid;
  logic           drain_ready;
  logic [RW-1:0]  drain_row;
  logic [31:0]    perf_cycles;

  modport master (
    output start, abort, k_len, drain_ready,
    input  busy, done, err, ld_en, ld_row, acc_clr, feed_en,
           drain_valid, drain_row, perf_cycles
  );

  modport slave (
    input  start, abort, k_len, drain_ready,
    output busy, done, err, ld_en, ld_row, acc_clr, feed_en,
           drain_valid, drain_row, perf_cycles
  );

endinterface

// File: rtl/systolic_tile_seq_skew_gen.sv
// Skewed per-row activation enables: row i is fed while i <= t < i + k_len.
module systolic_skew_gen
  import systolic_pkg::*;
#(
  parameter int DIM = DIM_DEF,
  parameter int KW  = KW_DEF,
  parameter int CW  = cnt_width(DIM_DEF, KW_DEF)
) (
  input  logic           en,
  input  logic [CW-1:0]  t,
  input  logic [KW-1:0]  k_len,
  output logic [DIM-1:0] feed_en
);
  localparam int EW = CW + 1;

  for (genvar i = 0; i < DIM; i++) begin : g_row
    logic [EW-1:0] t_ext;
    logic [EW-1:0] lo;
    logic [EW-1:0] hi;
    assign t_ext      = EW'(t);
    assign lo         = EW'(i);
    assign hi         = EW'(k_len) + EW'(i);
    assign feed_en[i] = en && (t_ext >= lo) && (t_ext < hi);
  end

endmodule

// File: rtl/systolic_tile_seq.sv
// Tile sequencer: weight load, skewed compute, handshaked drain, done pulse.
// Optional SYSTOLIC_SEQ_PERF_EN adds a cycle counter of the last completed operation.
module systolic_tile_seq
  import systolic_pkg::*;
#(
  parameter int DIM = DIM_DEF,
  parameter int KW  = KW_DEF
) (
  input  logic                clk,
  input  logic                rst,
  systolic_tile_seq_if.slave  bus
);
  localparam int RW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int CW = cnt_width(DIM, KW);
  localparam logic [CW-1:0] ROW_LAST = CW'(DIM - 1);
  localparam logic [CW-1:0] SKEW     = CW'(2 * DIM - 3);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [CW-1:0] t_last;
  logic [KW-1:0] k_lat;
  logic          err_q;
  logic          accept;

  assign accept = (state == IDLE) && bus.start && (bus.k_len != '0);
  assign t_last = CW'(k_lat) + SKEW;

  always_comb begin
    state_nxt = state;
    if (state != IDLE && bus.abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_nxt = LOAD;
        LOAD:    if (cnt == ROW_LAST) state_nxt = COMPUTE;
        COMPUTE: if (cnt == t_last) state_nxt = DRAIN;
        DRAIN:   if (bus.drain_ready && cnt == ROW_LAST) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // One counter serves as load row, compute step t and drain row; it restarts on every state change.
  always_comb begin
    cnt_nxt = '0;
    if (state_nxt == state) begin
      if (state == DRAIN)
        cnt_nxt = cnt + CW'(bus.drain_ready);
      else if (state == LOAD || state == COMPUTE)
        cnt_nxt = cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      err_q <= (state == IDLE) && bus.start && (bus.k_len == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) k_lat <= bus.k_len;
  end

  systolic_skew_gen #(
    .DIM (DIM),
    .KW  (KW),
    .CW  (CW)
  ) u_skew (
    .en      (state == COMPUTE),
    .t       (cnt),
    .k_len   (k_lat),
    .feed_en (bus.feed_en)
  );

  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE);
  assign bus.err         = err_q;
  assign bus.ld_en       = (state == LOAD);
  assign bus.ld_row      = (state == LOAD) ? cnt[RW-1:0] : '0;
  assign bus.acc_clr     = (state == LOAD) && (cnt == '0);
  assign bus.drain_valid = (state == DRAIN);
  assign bus.drain_row   = (state == DRAIN) ? cnt[RW-1:0] : '0;

`ifdef SYSTOLIC_SEQ_PERF_EN
  logic [31:0] run_cnt;
  logic [31:0] perf_q;

  // run_cnt equals the 1-based cycle index since LOAD entry; the DONE cycle itself is included.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_cnt <= '0;
      perf_q  <= '0;
    end else begin
      if (accept)
        run_cnt <= 32'd1;
      else if (state != IDLE)
        run_cnt <= run_cnt + 32'd1;
      if (state == DRAIN && state_nxt == DONE)
        perf_q <= run_cnt + 32'd1;
    end
  end

  assign bus.perf_cycles = perf_q;
`else
  assign bus.perf_cycles = '0;
`endif

endmodule

// File: tb/tb_systolic_tile_seq.sv
// Directed plus randomized bench for systolic_tile_seq at DIM=4, KW=16.
module tb_systolic_tile_seq;
  localparam int DIM = 4;
  localparam int KW  = 16;
`ifdef SYSTOLIC_SEQ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  systolic_tile_seq_if #(.DIM(DIM), .KW(KW)) bus ();
  systolic_tile_seq #(.DIM(DIM), .KW(KW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_perf = '0;
  logic [DIM-1:0] obs_feed [0:63];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"},    32'(bus.busy), 32'd0);
    chk({tag, "_done"},    32'(bus.done), 32'd0);
    chk({tag, "_err"},     32'(bus.err), 32'd0);
    chk({tag, "_ld_en"},   32'(bus.ld_en), 32'd0);
    chk({tag, "_ld_row"},  32'(bus.ld_row), 32'd0);
    chk({tag, "_acc_clr"}, 32'(bus.acc_clr), 32'd0);
    chk({tag, "_feed"},    32'(bus.feed_en), 32'd0);
    chk({tag, "_dvalid"},  32'(bus.drain_valid), 32'd0);
    chk({tag, "_drow"},    32'(bus.drain_row), 32'd0);
    chk({tag, "_perf"},    bus.perf_cycles, exp_perf);
  endtask

  // Row i of the array is fed during steps i .. i+k-1 of the compute window.
  function automatic logic [DIM-1:0] feed_model(input int t, input int k);
    logic [DIM-1:0] f;
    for (int i = 0; i < DIM; i++) f[i] = (t >= i) && (t < i + k);
    return f;
  endfunction

  // ready_mode: 0 always ready, 1 random ready, 2 ready low for 3 cycles at row 2.
  task automatic run_op(input int k, input int ready_mode, input int abort_at,
                        input int rst_at, output int done_cycle);
    int  win;
    int  rows;
    int  stall;
    int  ph;
    bit  fin;
    bit  rdy;
    win        = k + 2 * DIM - 2;
    rows       = 0;
    stall      = 0;
    fin        = 1'b0;
    done_cycle = -1;
    check_idle("pre");
    bus.start = 1'b1;
    bus.k_len = KW'(k);
    tick();
    for (int c = 1; c < 400 && !fin; c++) begin
      if (c <= DIM)            ph = 0;
      else if (c <= DIM + win) ph = 1;
      else if (rows < DIM)     ph = 2;
      else                     ph = 3;
      if (ph == 3) exp_perf = PERF ? 32'(c) : 32'd0;
      chk("busy",    32'(bus.busy), 32'd1);
      chk("done",    32'(bus.done), 32'(ph == 3));
      chk("err",     32'(bus.err), 32'd0);
      chk("ld_en",   32'(bus.ld_en), 32'(ph == 0));
      chk("ld_row",  32'(bus.ld_row), (ph == 0) ? 32'(c - 1) : 32'd0);
      chk("acc_clr", 32'(bus.acc_clr), 32'(ph == 0 && c == 1));
      chk("feed_en", 32'(bus.feed_en), (ph == 1) ? 32'(feed_model(c - DIM - 1, k)) : 32'd0);
      chk("dvalid",  32'(bus.drain_valid), 32'(ph == 2));
      chk("drow",    32'(bus.drain_row), (ph == 2) ? 32'(rows) : 32'd0);
      chk("perf",    bus.perf_cycles, exp_perf);
      obs_feed[c % 64] = bus.feed_en;
      if (bus.done) done_cycle = c;
      if (c == rst_at) begin
        bus.start = 1'b0;
        rst = 1'b0;
        #1;
        exp_perf = '0;
        check_idle("rst_async");
        tick();
        check_idle("rst_hold");
        rst = 1'b1;
        fin = 1'b1;
      end else if (c == abort_at) begin
        bus.start = 1'b0;
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check_idle("abort");
        fin = 1'b1;
      end else begin
        bus.start = (ph == 3) ? 1'b0 : 1'($urandom % 2);
        bus.k_len = KW'($urandom % 4);
        case (ready_mode)
          0:       rdy = 1'b1;
          1:       rdy = 1'($urandom % 2);
          default: rdy = !(rows == 2 && stall < 3);
        endcase
        bus.drain_ready = rdy;
        if (ph == 2 && !rdy) stall++;
        if (ph == 2 && rdy) rows++;
        tick();
        if (ph == 3) begin
          check_idle("post_done");
          fin = 1'b1;
        end
      end
    end
    chk("op_bounded", 32'(fin), 32'd1);
    bus.drain_ready = 1'b0;
  endtask

  initial begin
    int dc;
    logic [DIM-1:0] feed_tab [0:8];
    feed_tab = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100,
                 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.k_len       = '0;
    bus.drain_ready = 1'b0;
    #1;
    check_idle("reset");
    tick();
    tick();
    rst = 1'b1;

    // Nominal k=3 run with drain always ready.
    run_op(3, 0, -1, -1, dc);
    chk("nominal_done_cycle", 32'(dc), 32'd18);
    for (int j = 0; j < 9; j++) chk("nominal_feed_seq", 32'(obs_feed[5 + j]), 32'(feed_tab[j]));

    // Consumer stalls three cycles at drain row 2.
    run_op(3, 2, -1, -1, dc);
    chk("stall_done_cycle", 32'(dc), 32'd21);

    // Zero-length request is rejected.
    bus.start = 1'b1;
    bus.k_len = '0;
    tick();
    bus.start = 1'b0;
    chk("zero_err_pulse", 32'(bus.err), 32'd1);
    chk("zero_busy", 32'(bus.busy), 32'd0);
    chk("zero_ld_en", 32'(bus.ld_en), 32'd0);
    tick();
    check_idle("zero_after");

    // Abort in compute, then a normal run.
    run_op(3, 0, 8, -1, dc);
    chk("abort_no_done", 32'(dc), 32'hffffffff);
    run_op(3, 0, -1, -1, dc);
    chk("after_abort_done_cycle", 32'(dc), 32'd18);

    // Asynchronous reset mid-compute, then a full run.
    run_op(3, 0, -1, 10, dc);
    run_op(3, 0, -1, -1, dc);
    chk("after_rst_done_cycle", 32'(dc), 32'd18);

    // Shortest inner dimension.
    run_op(1, 0, -1, -1, dc);
    chk("k1_done_cycle", 32'(dc), 32'd16);

    // Randomized lengths, drain back-pressure and occasional aborts.
    for (int n = 0; n < 10; n++) begin
      int k;
      int mode;
      int ab;
      k    = int'($urandom_range(1, 12));
      mode = int'($urandom % 3);
      ab   = ($urandom % 4 == 0) ? int'($urandom_range(1, 25)) : -1;
      run_op(k, mode, ab, -1, dc);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
